discrete_channel_mixer: RTL and testbench
=========================================

DISCRETE_CHANNEL_MIXER -- requirements
Module: discrete_channel_mixer

Interface
REQ-001 Parameter NUM_CH, default 4: number of mixed channels, legal range 1..8.
REQ-002 clk  input  1  system clock.
REQ-003 I_RSTn  input  1  reset, asynchronous, active-low.
REQ-004 audio_clk_en  input  1  one-cycle sample strobe, starts one mix pass.
REQ-005 in  input  NUM_CH*16  packed signed channel samples; channel k occupies bits [16k+15:16k].
REQ-006 gain  input  NUM_CH*9  packed unsigned Q1.8 gains; channel k occupies bits [9k+8:9k]; 256 is unity.
REQ-007 out  output  16  signed mixed sample, registered.
REQ-008 out_valid  output  1  one-cycle pulse when out updates.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 overrun  output  1  sticky flag: a strobe arrived while busy.

Function
REQ-011 The FSM SHALL have states IDLE, ACCUM and DONE.
REQ-012 In IDLE with audio_clk_en=1, the block SHALL snapshot in and gain into internal registers, clear the accumulator, set the channel index to 0, and enter ACCUM.
REQ-013 In ACCUM, each cycle SHALL add snapshot_in[idx]*snapshot_gain[idx] (signed 16 x unsigned 9, 26-bit signed product) into a 28-bit signed accumulator, then increment idx.
REQ-014 When idx=NUM_CH-1 in ACCUM, the FSM SHALL enter DONE after that cycle's add.
REQ-015 In DONE, out SHALL load sat16(acc >>> 8) and out_valid SHALL pulse for one cycle, and the FSM SHALL return to IDLE.
REQ-016 The shift SHALL be arithmetic (floor toward minus infinity, no rounding).
REQ-017 sat16 SHALL clamp to +32767 / -32768.
REQ-018 Latency: out and out_valid SHALL update on the clock edge NUM_CH+1 edges after the edge that sampled audio_clk_en.
REQ-019 audio_clk_en in IDLE in the same cycle that DONE exits SHALL NOT occur: DONE is busy, so such a strobe is ignored.
REQ-020 audio_clk_en while busy SHALL be ignored, SHALL set overrun, and SHALL NOT alter the pass in progress.
REQ-021 Changes on in or gain during a pass SHALL NOT affect that pass.
REQ-022 out SHALL hold its last value between passes.
REQ-023 out_valid SHALL be 0 in all cycles other than the DONE exit edge.
REQ-024 overrun SHALL clear only on reset.

Reset
REQ-025 While I_RSTn=0, the block SHALL force the following, asynchronously: out=0, out_valid=0, overrun=0, state=IDLE, idx=0, acc=0, and snapshots=0.
REQ-026 Reset asserted mid-pass SHALL abort the pass with no out_valid pulse.
REQ-027 The first strobe after release SHALL start a clean pass.

Structure
REQ-028 Package discrete_mix_pkg SHALL hold:
- the state enum;
- GAIN_W=9, GAIN_UNITY=256, GAIN_SHIFT=8;
- ACC_W=28, SAMPLE_W=16;
- the sat16 function.
REQ-029 The sub-module discrete_mix_saturator (28-bit in, shift and clamp, 16-bit out) SHALL be the only sub-module; the MAC and FSM stay in the top.

Verification
REQ-030 Sum: NUM_CH=4, gains all 256, in={1000,2000,3000,4000}, one strobe -> out=10000, out_valid high exactly once, 5 edges after the strobe edge.
REQ-031 Saturation: gains 256, in all +30000 -> out=32767; in all -30000 -> out=-32768.
REQ-032 Floor shift: ch0=-3 with gain 128, other channels 0 -> out=-2; ch0=+3 with gain 128 -> out=1.
REQ-033 Overrun: a second strobe 2 cycles after the first -> overrun=1 and stays 1, exactly one out_valid pulse, out equals the first pass result.
REQ-034 Snapshot: change in to all 0 one cycle after the strobe (gains 256, in={1000,2000,3000,4000} at strobe) -> out=10000.
REQ-035 Reset mid-pass: assert I_RSTn=0 during ACCUM -> out=0, busy=0, overrun=0, no out_valid pulse; the next strobe produces the correct result.

Source files
------------

// File: rtl/discrete_mix_pkg.sv
// discrete_mix_pkg
//   Shared types, widths and helpers for the discrete channel mixer.
//   - mix_state_e : mixer FSM state encoding
//   - GAIN_*      : Q1.8 unsigned gain format (256 == unity)
//   - ACC_W       : width of the signed MAC accumulator
//   - SAMPLE_W    : width of signed audio samples
//   - sat16()     : clamp an accumulator-width value to the signed sample range
package discrete_mix_pkg;

    localparam int unsigned GAIN_W     = 9;
    localparam int unsigned GAIN_UNITY = 256;
    localparam int unsigned GAIN_SHIFT = $clog2(GAIN_UNITY);
    localparam int unsigned ACC_W      = 28;
    localparam int unsigned SAMPLE_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } mix_state_e;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    // Bitwise complement of +32767 in two's complement is -32768.
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        logic signed [SAMPLE_W-1:0] r;
        if (v > SAT_MAX) begin
            r = 16'sh7FFF;
        end else if (v < SAT_MIN) begin
            r = 16'sh8000;
        end else begin
            r = v[SAMPLE_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/discrete_mix_saturator.sv
// discrete_mix_saturator
//   Converts the mixer accumulator back to a sample: arithmetic right shift by
//   the gain fraction width (floor, no rounding), then clamp to 16-bit signed.
//   Ports:
//     acc_in  : signed accumulator value (ACC_W bits)
//     sat_out : signed saturated sample (SAMPLE_W bits), combinational
module discrete_mix_saturator
    import discrete_mix_pkg::*;
(
    input  logic signed [ACC_W-1:0]    acc_in,
    output logic signed [SAMPLE_W-1:0] sat_out
);

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc_in >>> GAIN_SHIFT;
        sat_out = sat16(shifted);
    end

endmodule

// File: rtl/discrete_channel_mixer.sv
// discrete_channel_mixer
//   Sequential gain-weighted mixer. A strobe on audio_clk_en snapshots all
//   channel samples and gains, then one channel per cycle is multiplied and
//   accumulated. After the last channel the accumulator is shifted, clamped
//   and registered on out with a one-cycle out_valid pulse.
//   Ports:
//     clk          : system clock
//     I_RSTn       : asynchronous active-low reset
//     audio_clk_en : sample strobe, starts a mix pass when idle
//     in           : NUM_CH packed signed 16-bit samples, channel k at [16k+15:16k]
//     gain         : NUM_CH packed unsigned Q1.8 gains, channel k at [9k+8:9k]
//     out          : registered signed mixed sample, holds between passes
//     out_valid    : one-cycle pulse when out updates
//     busy         : high whenever a pass is in progress (state not IDLE)
//     overrun      : sticky, set by a strobe arriving while busy; reset only
module discrete_channel_mixer
    import discrete_mix_pkg::*;
#(
    parameter int unsigned NUM_CH = 4
) (
    input  logic                         clk,
    input  logic                         I_RSTn,
    input  logic                         audio_clk_en,
    input  logic [NUM_CH*SAMPLE_W-1:0]   in,
    input  logic [NUM_CH*GAIN_W-1:0]     gain,
    output logic signed [SAMPLE_W-1:0]   out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PROD_W = SAMPLE_W + GAIN_W + 1;

    mix_state_e                  state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic signed [SAMPLE_W-1:0]  snap_in_q   [NUM_CH];
    logic signed [SAMPLE_W-1:0]  snap_in_d   [NUM_CH];
    logic [GAIN_W-1:0]           snap_gain_q [NUM_CH];
    logic [GAIN_W-1:0]           snap_gain_d [NUM_CH];
    logic signed [SAMPLE_W-1:0]  out_q, out_d;
    logic                        out_valid_q, out_valid_d;
    logic                        overrun_q, overrun_d;

    logic signed [PROD_W-1:0]    prod;
    logic signed [SAMPLE_W-1:0]  sat_out;
    logic                        busy_w;

    discrete_mix_saturator u_sat (
        .acc_in  (acc_q),
        .sat_out (sat_out)
    );

    assign busy_w = (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        snap_in_d   = snap_in_q;
        snap_gain_d = snap_gain_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        // Any strobe seen while busy (ACCUM or DONE) is dropped but flagged.
        overrun_d   = overrun_q | (audio_clk_en & busy_w);

        // Signed sample times zero-extended unsigned gain, both widened first
        // so the multiply is evaluated at full product width.
        prod = PROD_W'(snap_in_q[idx_q]) * PROD_W'($signed({1'b0, snap_gain_q[idx_q]}));

        unique case (state_q)
            ST_IDLE: begin
                if (audio_clk_en) begin
                    for (int unsigned k = 0; k < NUM_CH; k++) begin
                        snap_in_d[k]   = in[k*SAMPLE_W +: SAMPLE_W];
                        snap_gain_d[k] = gain[k*GAIN_W +: GAIN_W];
                    end
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + ACC_W'(prod);
                if (idx_q == IDX_W'(NUM_CH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                out_d       = sat_out;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                snap_in_q[k]   <= '0;
                snap_gain_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            snap_in_q   <= snap_in_d;
            snap_gain_q <= snap_gain_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_w;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_discrete_channel_mixer.sv
// tb_discrete_channel_mixer
//   Directed self-checking bench for discrete_channel_mixer with NUM_CH=4.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_discrete_channel_mixer;

    localparam int unsigned NCH = 4;

    logic                    clk;
    logic                    I_RSTn;
    logic                    audio_clk_en;
    logic [NCH*16-1:0]       in_v;
    logic [NCH*9-1:0]        gain_v;
    logic signed [15:0]      out_w;
    logic                    out_valid;
    logic                    busy;
    logic                    overrun;

    int errors = 0;
    int checks = 0;

    discrete_channel_mixer #(.NUM_CH(NCH)) dut (
        .clk          (clk),
        .I_RSTn       (I_RSTn),
        .audio_clk_en (audio_clk_en),
        .in           (in_v),
        .gain         (gain_v),
        .out          (out_w),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_ch(input int k, input logic signed [15:0] s, input logic [8:0] g);
        in_v[16*k +: 16] = s;
        gain_v[9*k +: 9] = g;
    endtask

    task automatic set_all(input logic signed [15:0] s0, input logic signed [15:0] s1,
                           input logic signed [15:0] s2, input logic signed [15:0] s3,
                           input logic [8:0] g);
        set_ch(0, s0, g);
        set_ch(1, s1, g);
        set_ch(2, s2, g);
        set_ch(3, s3, g);
    endtask

    // Strobe once, then observe 8 falling edges; report pulse count, the edge
    // index (relative to the strobe-sampling edge) of the first pulse, and out there.
    task automatic run_pass(output int cnt, output int first, output logic signed [15:0] val);
        cnt   = 0;
        first = 0;
        val   = '0;
        @(negedge clk);
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (out_valid) begin
                cnt++;
                if (first == 0) begin
                    first = i;
                    val   = out_w;
                end
            end
        end
    endtask

    task automatic test_reset();
        I_RSTn       = 1'b1;
        audio_clk_en = 1'b0;
        in_v         = '0;
        gain_v       = '0;
        #1 I_RSTn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_w !== 16'sd0) begin errors++; $display("FAIL reset_out: got %0d want 0", out_w); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        I_RSTn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sum();
        int cnt, first;
        logic signed [15:0] val;
        set_all(16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000, 9'd256);
        run_pass(cnt, first, val);
        checks++; if (val !== 16'sd10000) begin errors++; $display("FAIL sum_out: got %0d want 10000", val); end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL sum_pulses: got %0d want 1", cnt); end
        checks++; if (first !== 5) begin errors++; $display("FAIL sum_latency: got %0d want 5", first); end
        checks++; if (out_w !== 16'sd10000) begin errors++; $display("FAIL sum_hold: got %0d want 10000", out_w); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sum_idle: got %b want 0", busy); end
    endtask

    task automatic test_weights();
        int cnt, first;
        logic signed [15:0] val;
        // 256*256 + 512*128 - 768*64 + 1024*32 = 114688 ; >>8 = 448
        set_ch(0, 16'sd256, 9'd256);
        set_ch(1, 16'sd512, 9'd128);
        set_ch(2, -16'sd768, 9'd64);
        set_ch(3, 16'sd1024, 9'd32);
        run_pass(cnt, first, val);
        checks++; if (val !== 16'sd448) begin errors++; $display("FAIL weights_out: got %0d want 448", val); end
        // 100*511 - 200*256 = -100 ; floor(-100/256) = -1
        set_ch(0, 16'sd100, 9'd511);
        set_ch(1, -16'sd200, 9'd256);
        set_ch(2, 16'sd300, 9'd0);
        set_ch(3, 16'sd0, 9'd128);
        run_pass(cnt, first, val);
        checks++; if (val !== -16'sd1) begin errors++; $display("FAIL gain511_out: got %0d want -1", val); end
    endtask

    task automatic test_saturation();
        int cnt, first;
        logic signed [15:0] val;
        set_all(16'sd30000, 16'sd30000, 16'sd30000, 16'sd30000, 9'd256);
        run_pass(cnt, first, val);
        checks++; if (val !== 16'sd32767) begin errors++; $display("FAIL sat_pos: got %0d want 32767", val); end
        set_all(-16'sd30000, -16'sd30000, -16'sd30000, -16'sd30000, 9'd256);
        run_pass(cnt, first, val);
        checks++; if (val !== -16'sd32768) begin errors++; $display("FAIL sat_neg: got %0d want -32768", val); end
    endtask

    task automatic test_floor_shift();
        int cnt, first;
        logic signed [15:0] val;
        set_all(16'sd0, 16'sd0, 16'sd0, 16'sd0, 9'd256);
        set_ch(0, -16'sd3, 9'd128);
        run_pass(cnt, first, val);
        checks++; if (val !== -16'sd2) begin errors++; $display("FAIL floor_neg: got %0d want -2", val); end
        set_ch(0, 16'sd3, 9'd128);
        run_pass(cnt, first, val);
        checks++; if (val !== 16'sd1) begin errors++; $display("FAIL floor_pos: got %0d want 1", val); end
    endtask

    task automatic test_overrun();
        int cnt, first;
        logic signed [15:0] val;
        cnt   = 0;
        first = 0;
        val   = '0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: got %b want 0", overrun); end
        set_all(16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000, 9'd256);
        @(negedge clk);
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL overrun_busy: got %b want 1", busy); end
        @(negedge clk);
        // Second strobe sampled two edges after the first, with new inputs.
        audio_clk_en = 1'b1;
        set_all(16'sd0, 16'sd0, 16'sd0, 16'sd0, 9'd0);
        @(negedge clk);
        audio_clk_en = 1'b0;
        for (int i = 3; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                cnt++;
                if (first == 0) begin
                    first = i;
                    val   = out_w;
                end
            end
        end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", overrun); end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL overrun_pulses: got %0d want 1", cnt); end
        checks++; if (first !== 5) begin errors++; $display("FAIL overrun_latency: got %0d want 5", first); end
        checks++; if (val !== 16'sd10000) begin errors++; $display("FAIL overrun_out: got %0d want 10000", val); end
    endtask

    task automatic test_snapshot();
        int cnt, first;
        logic signed [15:0] val;
        cnt   = 0;
        first = 0;
        val   = '0;
        set_all(16'sd500, 16'sd1500, 16'sd2500, 16'sd3500, 9'd256);
        @(negedge clk);
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        in_v   = '0;
        gain_v = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (out_valid) begin
                cnt++;
                if (first == 0) begin
                    first = i;
                    val   = out_w;
                end
            end
        end
        checks++; if (val !== 16'sd8000) begin errors++; $display("FAIL snapshot_out: got %0d want 8000", val); end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL snapshot_pulses: got %0d want 1", cnt); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_reset_midpass();
        int cnt, first;
        logic signed [15:0] val;
        int pulses;
        pulses = 0;
        set_all(16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000, 9'd256);
        @(negedge clk);
        audio_clk_en = 1'b1;
        @(negedge clk);
        audio_clk_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        I_RSTn = 1'b0;
        #1;
        checks++; if (out_w !== 16'sd0) begin errors++; $display("FAIL midrst_out: got %0d want 0", out_w); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun: got %b want 0", overrun); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        I_RSTn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_pulses: got %0d want 0", pulses); end
        set_all(16'sd100, 16'sd200, 16'sd300, 16'sd400, 9'd256);
        run_pass(cnt, first, val);
        checks++; if (val !== 16'sd1000) begin errors++; $display("FAIL midrst_next_out: got %0d want 1000", val); end
        checks++; if (first !== 5) begin errors++; $display("FAIL midrst_next_latency: got %0d want 5", first); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_next_overrun: got %b want 0", overrun); end
    endtask

    initial begin
        test_reset();
        test_sum();
        test_weights();
        test_saturation();
        test_floor_shift();
        test_overrun();
        test_snapshot();
        test_reset_midpass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
